// File: rtl/uart_sync_fifo_pkg.sv
// Shared sizing constants for the UART synchronous FIFO and its RAM.
package uart_sync_fifo_pkg;

    localparam int unsigned FIFO_WIDTH_DEF = 8;
    localparam int unsigned FIFO_BITS_DEF  = 8;
    localparam int unsigned FIFO_DEPTH     = 256;

    // Number of RAM words addressed by a pointer of the given width.
    function automatic int unsigned depth_of(input int unsigned bits);
        return 32'd1 << bits;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Inferred simple dual-port RAM: one write port, one registered read port, one clock.
module uart_fifo_ram
    import uart_sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_WIDTH_DEF,
    parameter int unsigned ADDR_W = FIFO_BITS_DEF
) (
    input  logic              clock,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // No reset on the array or read register so the tools can map this to block RAM.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_sync_fifo.sv
// Synchronous ring-buffer FIFO (255 usable entries) with full/empty/half flags
// and a two-edge registered read path.
module uart_sync_fifo
    import uart_sync_fifo_pkg::*;
#(
    parameter int unsigned              FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int unsigned              FIFO_BITS  = FIFO_BITS_DEF,
    parameter logic [FIFO_BITS-1:0]     LEVEL      = FIFO_BITS'(128)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  write_n,
    input  logic                  read_n,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  half
);

    logic [FIFO_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FIFO_BITS-1:0]  count_q,  count_d;
    logic                  read_hold_q;
    logic [FIFO_WIDTH-1:0] data_out_q;
    logic [FIFO_WIDTH-1:0] ram_rd_data;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags decode the registered count directly.
    assign full  = (count_q == {FIFO_BITS{1'b1}});
    assign empty = (count_q == '0);
    assign half  = (count_q >= LEVEL);

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = ~read_n & ~empty;
    assign wr_acc = ~write_n & (~full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + FIFO_BITS'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + FIFO_BITS'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + FIFO_BITS'(1);
            2'b01:   count_d = count_q - FIFO_BITS'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            read_hold_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            read_hold_q <= rd_acc;
            if (read_hold_q) begin
                data_out_q <= ram_rd_data;
            end
        end
    end

    assign data_out = data_out_q;

    uart_fifo_ram #(
        .DATA_W (FIFO_WIDTH),
        .ADDR_W (FIFO_BITS)
    ) u_ram (
        .clock     (clock),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (data_in),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rd_data)
    );

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Scoreboard bench for uart_sync_fifo: stimulus queues expected read bytes,
// a monitor compares data_out two edges after each issued read.
module tb_uart_sync_fifo;

    logic       clock;
    logic       reset_n;
    logic [7:0] data_in;
    logic       write_n;
    logic       read_n;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       half;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic       rd_tag = 1'b0;
    logic [1:0] pipe;

    uart_sync_fifo dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .data_in  (data_in),
        .write_n  (write_n),
        .read_n   (read_n),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
        .half     (half)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; a read that should be accepted queues its byte.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d,
                       input logic exp_rd, input logic [7:0] exp_d);
        write_n = ~w;
        read_n  = ~r;
        data_in = d;
        rd_tag  = exp_rd;
        if (exp_rd) exp_q.push_back(exp_d);
        @(posedge clock);
        #1;
        write_n = 1'b1;
        read_n  = 1'b1;
        rd_tag  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) pipe <= 2'b00;
        else          pipe <= {pipe[0], rd_tag};
    end

    // Monitor: data_out is valid after the second edge following an accepted read.
    always @(negedge clock) begin
        logic [7:0] e;
        if (reset_n && pipe[1]) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_data: got 0x%0h with no expected byte queued", data_out);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", {24'h0, data_out}, {24'h0, e});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wseq, rseq, occ, c;
        logic w, r;

        reset_n = 1'b0;
        write_n = 1'b1;
        read_n  = 1'b1;
        data_in = 8'h00;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("rst_empty", {31'h0, empty}, 32'd1);
        chk("rst_full",  {31'h0, full},  32'd0);
        chk("rst_half",  {31'h0, half},  32'd0);
        chk("rst_dout",  {24'h0, data_out}, 32'h00);
        reset_n = 1'b1;
        idle(1);

        // Basic write/read
        cyc(1'b1, 1'b0, 8'hA5, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h3C, 1'b0, 8'h00);
        chk("basic_empty0", {31'h0, empty}, 32'd0);
        cyc(1'b0, 1'b1, 8'h00, 1'b1, 8'hA5);
        cyc(1'b0, 1'b1, 8'h00, 1'b1, 8'h3C);
        idle(2);
        chk("basic_empty1", {31'h0, empty}, 32'd1);
        chk("basic_dout",   {24'h0, data_out}, 32'h3C);

        // Fill to 255, checking half and full thresholds
        for (int i = 0; i < 255; i++) begin
            cyc(1'b1, 1'b0, 8'(i), 1'b0, 8'h00);
            if (i == 126) chk("half_at127", {31'h0, half}, 32'd0);
            if (i == 127) chk("half_at128", {31'h0, half}, 32'd1);
            if (i == 253) chk("full_at254", {31'h0, full}, 32'd0);
        end
        chk("fill_full", {31'h0, full}, 32'd1);
        chk("fill_half", {31'h0, half}, 32'd1);
        cyc(1'b1, 1'b0, 8'hEE, 1'b0, 8'h00);
        chk("ovf_full", {31'h0, full}, 32'd1);
        chk("ovf_empty", {31'h0, empty}, 32'd0);
        // Simultaneous access while full: both accepted, stays full
        cyc(1'b1, 1'b1, 8'hFF, 1'b1, 8'h00);
        chk("full_rw_full", {31'h0, full}, 32'd1);
        for (int i = 1; i < 255; i++) cyc(1'b0, 1'b1, 8'h00, 1'b1, 8'(i));
        chk("drain_one_left", {31'h0, empty}, 32'd0);
        cyc(1'b0, 1'b1, 8'h00, 1'b1, 8'hFF);
        idle(2);
        chk("drain_empty", {31'h0, empty}, 32'd1);
        chk("drain_half",  {31'h0, half},  32'd0);

        // Underflow: read while empty is ignored
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
        idle(2);
        chk("udf_dout",  {24'h0, data_out}, 32'hFF);
        chk("udf_empty", {31'h0, empty}, 32'd1);
        cyc(1'b1, 1'b1, 8'h77, 1'b0, 8'h00);
        idle(2);
        chk("udf_rw_empty", {31'h0, empty}, 32'd0);
        chk("udf_rw_dout",  {24'h0, data_out}, 32'hFF);
        cyc(1'b0, 1'b1, 8'h00, 1'b1, 8'h77);
        idle(2);
        chk("udf_rd_empty", {31'h0, empty}, 32'd1);

        // Simultaneous access with count=10
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 8'h00);
        for (int i = 0; i < 5; i++)  cyc(1'b1, 1'b1, 8'(8'h20 + i), 1'b1, 8'(8'h10 + i));
        for (int i = 0; i < 5; i++)  cyc(1'b0, 1'b1, 8'h00, 1'b1, 8'(8'h15 + i));
        for (int i = 0; i < 4; i++)  cyc(1'b0, 1'b1, 8'h00, 1'b1, 8'(8'h20 + i));
        chk("sim_one_left", {31'h0, empty}, 32'd0);
        cyc(1'b0, 1'b1, 8'h00, 1'b1, 8'h24);
        idle(2);
        chk("sim_empty", {31'h0, empty}, 32'd1);

        // 600-byte stream with interleaved reads across pointer wrap
        wseq = 0; rseq = 0; occ = 0; c = 0;
        while (rseq < 600) begin
            w = (wseq < 600);
            r = (occ > 0) && ((c % 3 != 0) || (wseq >= 600));
            cyc(w, r, 8'(wseq), r, 8'(rseq));
            if (w) wseq++;
            if (r) rseq++;
            occ = occ + int'(w) - int'(r);
            c++;
        end
        idle(2);
        chk("wrap_empty", {31'h0, empty}, 32'd1);
        chk("wrap_dout",  {24'h0, data_out}, 32'h57);

        // Reset with count=50 clears state asynchronously
        for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 8'h00);
        chk("pre_rst_empty", {31'h0, empty}, 32'd0);
        chk("pre_rst_half",  {31'h0, half},  32'd0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_empty", {31'h0, empty}, 32'd1);
        chk("mid_rst_dout",  {24'h0, data_out}, 32'h00);
        chk("mid_rst_full",  {31'h0, full}, 32'd0);
        exp_q.delete();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        cyc(1'b1, 1'b0, 8'h5A, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h00, 1'b1, 8'h5A);
        idle(3);
        chk("post_rst_empty", {31'h0, empty}, 32'd1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_sync_fifo.md
UART_SYNC_FIFO -- requirements
Module: uart_sync_fifo

Interface
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 8: data width in bits.
REQ-002 The block SHALL have parameter FIFO_BITS, default 8: pointer and count width; memory depth is 2**FIFO_BITS = 256.
REQ-003 The block SHALL have parameter LEVEL, FIFO_BITS wide, default 128: threshold for the half flag.
REQ-004 The block SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port data_in, input, FIFO_WIDTH bits: write data.
REQ-007 The block SHALL have port write_n, input, 1 bit: write request, active low.
REQ-008 The block SHALL have port read_n, input, 1 bit: read request, active low.
REQ-009 The block SHALL have port data_out, output, FIFO_WIDTH bits: registered read data.
REQ-010 The block SHALL have port full, output, 1 bit: high when count equals 255.
REQ-011 The block SHALL have port empty, output, 1 bit: high when count equals 0.
REQ-012 The block SHALL have port half, output, 1 bit: high when count is greater than or equal to LEVEL.

Function
REQ-013 Storage SHALL be a 256 x FIFO_WIDTH ring buffer with wr_pointer, rd_pointer and count, each FIFO_BITS wide; usable capacity SHALL be 255 entries.
REQ-014 An accepted write (write_n=0 and not full) SHALL store data_in at wr_pointer and increment wr_pointer modulo 256.
REQ-015 An accepted read (read_n=0 and not empty) SHALL increment rd_pointer modulo 256.
REQ-016 count SHALL increment on a write-only cycle, decrement on a read-only cycle, and stay unchanged on a simultaneous accepted read and write.
REQ-017 A write while full with no read SHALL be ignored: no pointer change, no count change, no memory change.
REQ-018 A simultaneous read and write while full SHALL both be accepted; count stays 255.
REQ-019 A read while empty SHALL be ignored: rd_pointer unchanged and data_out unchanged.
REQ-020 On a simultaneous read and write while empty, only the write SHALL be accepted; count becomes 1.
REQ-021 Read latency: at edge N with an accepted read, the RAM output SHALL register mem[rd_pointer] and a 1-bit read_hold SHALL register the read; at edge N+1, data_out SHALL load the RAM output. Data is therefore valid after the second rising edge.
REQ-022 data_out SHALL hold its value in all other cycles.
REQ-023 full, empty and half SHALL be combinational decodes of count and SHALL update in the cycle after the edge that changes count.
REQ-024 Pointer wrap from 255 to 0 SHALL be seamless; data order SHALL be preserved across the wrap.

Reset
REQ-025 Asserting reset_n low SHALL asynchronously clear wr_pointer, rd_pointer, count, read_hold and data_out to 0, giving empty=1, full=0, and half=(LEVEL==0).
REQ-026 Reset asserted mid-operation SHALL discard all FIFO contents; memory contents need not be cleared.
REQ-027 Reset release SHALL be synchronized externally; the block SHALL use reset_n directly.

Structure
REQ-028 A shared package SHALL hold the FIFO_WIDTH and FIFO_BITS defaults and the depth constant (256).
REQ-029 A single sub-module, uart_fifo_ram, SHALL implement the memory as an inferred simple dual-port RAM with:
- one write port, enabled by the accepted write;
- one synchronous read port, enabled by the accepted read;
- the same clock for both ports;
- no vendor primitives.
REQ-030 Pointer, count, flag and output-register logic SHALL reside in uart_sync_fifo.

Verification
REQ-031 Reset scenario: reset with LEVEL=128 -> empty=1, full=0, half=0, data_out=0x00.
REQ-032 Basic write/read scenario:
- write 0xA5 then 0x3C -> empty=0;
- read once -> data_out=0xA5 after the second edge;
- read again -> data_out=0x3C;
- then empty=1.
REQ-033 Fill scenario: write 255 bytes 0x00..0xFE -> full=1 and half=1 (half asserted from the 128th write onward); a 256th write 0xFF is ignored; reading all 255 bytes returns 0x00..0xFE in order, then empty=1.
REQ-034 Simultaneous access scenario: with count=10, drive read_n=0 and write_n=0 for 5 cycles -> count stays 10 and the read data is the oldest 5 entries.
REQ-035 Underflow scenario: read while empty -> data_out unchanged and empty stays 1; simultaneous read and write while empty -> count=1 and the next read returns the written byte.
REQ-036 Wrap and reset scenario:
- stream 600 bytes with interleaved reads -> order preserved across the pointer wrap;
- assert reset_n with count=50 -> immediately empty=1 and data_out=0x00.
